// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int ID_W      = $clog2(MAX_REQ);
  // Start timeout counter: START_TIMEOUT up to 255 clocks.
  localparam int TO_CNT_W  = 8;
  // Post-frame gap counter: GAP_CYCLES up to 15 clocks.
  localparam int GAP_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; onehot is all-zero when no request is pending.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    index
);

  // Walk the ring starting at ptr and keep the first hit.
  always_comb begin
    logic found;
    int   j;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        index     = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_send transmitter among NUM_REQ requesters (round-robin, or fixed priority with UART_ARB_FIXED_PRIO_EN).
// Latency: request to ack 2 clocks, ack to uart_en rising 1 clock; GAP_CYCLES idle clocks after busy falls.
// Backpressure: requesters hold req/byte until ack; an unstarted transmitter sets sticky start_err and drops the byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic                 arb_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 start_err
);

  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(START_TIMEOUT - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 uart_en_q, uart_en_d;
  logic [7:0]           din_q, din_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 err_q, err_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]      pick_idx;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Lowest-numbered pending requester always wins; no rotation state.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
        pick_idx       = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  // Pointer moves just past the winner, only on a grant that actually acks.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == GRANT && |req) begin
      ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  // Round-robin pointer register; requester 0 is favoured after reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`endif

  // Next-state and output decode. uart_en is only ever driven high from
  // LAUNCH, and only from the second LAUNCH cycle, so each byte gives the
  // transmitter's edge detector exactly one clean rising edge after ack.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    uart_en_d = 1'b0;
    din_d     = din_q;
    grant_d   = grant_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        // A busy transmitter here belongs to someone else or is stale.
        if (|req && !uart_tx_busy) state_d = GRANT;
      end
      GRANT: begin
        if (|req) begin
          state_d  = LAUNCH;
          ack_d    = pick_onehot;
          din_d    = req_data[8*int'(pick_idx) +: 8];
          grant_d  = pick_idx;
          to_cnt_d = '0;
        end else begin
          // Request withdrawn before ack: nothing latched, nothing sent.
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (uart_en_q) begin
          if (to_cnt_q == TO_LAST) begin
            // Transmitter never started: flag it and drop this byte.
            err_d     = 1'b1;
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            to_cnt_d  = to_cnt_q + 1'b1;
            uart_en_d = 1'b1;
          end
        end else begin
          uart_en_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      uart_en_q <= 1'b0;
      din_q     <= '0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      uart_en_q <= uart_en_d;
      din_q     <= din_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign ack       = ack_q;
  assign uart_en   = uart_en_q;
  assign uart_din  = din_q;
  assign grant_id  = grant_q;
  assign start_err = err_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with an edge-triggered transmitter model and line decoder.
// Expected grants/bytes are queued when requests are driven and popped on ack and on decoded frames.
// Honours UART_ARB_FIXED_PRIO_EN for the contention ordering.
module tb_uart_tx_arbiter;

  localparam int BIT = 4;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        m_busy;
  logic        arb_busy;
  logic [2:0]  grant_id;
  logic        start_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .START_TIMEOUT (8),
    .GAP_CYCLES    (2)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (m_busy),
    .arb_busy     (arb_busy),
    .grant_id     (grant_id),
    .start_err    (start_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] line_q[$];
  logic [7:0] rx_q[$];

  // Transmitter model: 2-flop edge detect on uart_en, 8N1 frame, BIT clocks per bit.
  logic       dead;
  logic       en_s1, en_s2;
  logic [9:0] sh;
  int         tick, bitn;
  logic       tx_line;

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_s1  <= 1'b0;
      en_s2  <= 1'b0;
      m_busy <= 1'b0;
      sh     <= '1;
      tick   <= 0;
      bitn   <= 0;
    end else begin
      en_s1 <= uart_en;
      en_s2 <= en_s1;
      if (!m_busy) begin
        if (en_s1 && !en_s2 && !dead) begin
          m_busy <= 1'b1;
          sh     <= {1'b1, uart_din, 1'b0};
          tick   <= 0;
          bitn   <= 0;
        end
      end else if (tick == BIT - 1) begin
        tick <= 0;
        sh   <= {1'b1, sh[9:1]};
        if (bitn == 9) m_busy <= 1'b0;
        else           bitn   <= bitn + 1;
      end else begin
        tick <= tick + 1;
      end
    end
  end

  assign tx_line = m_busy ? sh[0] : 1'b1;

  // Line decoder: samples mid-bit on falling clock edges.
  initial begin
    forever begin
      logic [7:0] b;
      b = '0;
      @(negedge tx_line);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = tx_line;
      end
      repeat (BIT) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  // Event counters for acks and uart_en rising edges.
  int   ack_cnt = 0, ack0_cnt = 0, en_rise = 0;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (|ack)   ack_cnt++;
    if (ack[0]) ack0_cnt++;
    if (uart_en && !en_prev) en_rise++;
    en_prev = uart_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [7:0] b, input bit on_line);
    exp_t e;
    e.id = id;
    e.b  = b;
    exp_q.push_back(e);
    if (on_line) line_q.push_back(b);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (|ack) break;
    end
    chk("ack_seen", 32'(|ack), 32'd1);
  endtask

  task automatic check_ack(output int cyc);
    exp_t e;
    wait_ack(cyc);
    if (exp_q.size() == 0) begin
      chk("ack_unexpected", 32'(ack), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("ack_vec", 32'(ack), 32'd1 << e.id);
      chk("grant_id", 32'(grant_id), 32'(e.id));
      chk("uart_din", 32'(uart_din), 32'(e.b));
    end
  endtask

  task automatic wait_busy(input logic level);
    int n = 0;
    while (m_busy !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_busy_level", 32'(m_busy), 32'(level));
  endtask

  task automatic wait_idle();
    int n = 0, quiet = 0;
    while (quiet < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!arb_busy && !m_busy) quiet++;
      else                      quiet = 0;
    end
    chk("idle_reached", 32'(quiet), 32'd3);
  endtask

  task automatic check_lines();
    logic [7:0] e;
    logic [8:0] got;
    while (line_q.size() > 0) begin
      e   = line_q.pop_front();
      got = (rx_q.size() == 0) ? 9'h1FF : {1'b0, rx_q.pop_front()};
      chk("line_byte", 32'(got), 32'(e));
    end
    chk("line_extra", 32'(rx_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"},       32'(ack),       32'd0);
    chk({tag, "_uart_en"},   32'(uart_en),   32'd0);
    chk({tag, "_uart_din"},  32'(uart_din),  32'd0);
    chk({tag, "_arb_busy"},  32'(arb_busy),  32'd0);
    chk({tag, "_grant_id"},  32'(grant_id),  32'd0);
    chk({tag, "_start_err"}, 32'(start_err), 32'd0);
  endtask

  initial begin
    int cyc, n, a0, e0, z0, nexp;
    sys_rst_n = 1'b0;
    req       = '0;
    req_data  = '0;
    dead      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: all four pending from a fresh pointer.
    req_data = 32'h1312_1110;
`ifdef UART_ARB_FIXED_PRIO_EN
    nexp = 3;
    for (int i = 0; i < 3; i++) push_exp(3'd0, 8'h10, 1'b1);
`else
    nexp = 5;
    push_exp(3'd0, 8'h10, 1'b1);
    push_exp(3'd1, 8'h11, 1'b1);
    push_exp(3'd2, 8'h12, 1'b1);
    push_exp(3'd3, 8'h13, 1'b1);
    push_exp(3'd0, 8'h10, 1'b1);
`endif
    a0  = ack_cnt;
    req = 4'b1111;
    for (int i = 0; i < nexp; i++) check_ack(cyc);
    req = '0;
    wait_idle();
    check_lines();
    chk("cont_ack_count", 32'(ack_cnt - a0), 32'(nexp));

    // Single byte from requester 1.
    req_data = 32'h0000_5500;
    push_exp(3'd1, 8'h55, 1'b1);
    a0  = ack_cnt;
    e0  = en_rise;
    req = 4'b0010;
    check_ack(cyc);
    req = '0;
    chk("ack_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    chk("en_after_ack", 32'(uart_en), 32'd1);
    wait_busy(1'b1);
    wait_busy(1'b0);
    n = 0;
    while (arb_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gap_to_idle", 32'(n), 32'd3);
    wait_idle();
    check_lines();
    chk("single_ack_count", 32'(ack_cnt - a0), 32'd1);
    chk("single_en_rises", 32'(en_rise - e0), 32'd1);

    // Back-to-back from requester 2 with a fresh byte after each ack.
    req_data = 32'h00A0_0000;
    push_exp(3'd2, 8'hA0, 1'b1);
    push_exp(3'd2, 8'hA1, 1'b1);
    push_exp(3'd2, 8'hA2, 1'b1);
    a0  = ack_cnt;
    e0  = en_rise;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      check_ack(cyc);
      req_data[23:16] = 8'(8'hA1 + i);
      if (i == 2) req = '0;
    end
    wait_idle();
    check_lines();
    chk("b2b_ack_count", 32'(ack_cnt - a0), 32'd3);
    chk("b2b_en_rises", 32'(en_rise - e0), 32'd3);

    // Start timeout: transmitter never goes busy.
    dead     = 1'b1;
    req_data = 32'h0000_7700;
    push_exp(3'd1, 8'h77, 1'b0);
    req = 4'b0010;
    check_ack(cyc);
    req = '0;
    n = 0;
    while (!uart_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (uart_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("en_high_clocks", 32'(n), 32'd8);
    chk("start_err_set", 32'(start_err), 32'd1);
    wait_idle();
    chk("timeout_idle", 32'(arb_busy), 32'd0);
    dead = 1'b0;
    chk("timeout_no_frame", 32'(rx_q.size()), 32'd0);
    req_data = 32'h3C00_0000;
    push_exp(3'd3, 8'h3C, 1'b1);
    req = 4'b1000;
    check_ack(cyc);
    req = '0;
    wait_idle();
    check_lines();
    chk("start_err_sticky", 32'(start_err), 32'd1);

    // Reset during WAIT_DONE.
    req_data = 32'h005A_0000;
    push_exp(3'd2, 8'h5A, 1'b0);
    req = 4'b0100;
    check_ack(cyc);
    req = '0;
    wait_busy(1'b1);
    repeat (3) @(negedge clk);
    chk("in_wait_done", 32'(arb_busy), 32'd1);
    a0 = ack_cnt;
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    chk("no_ack_after_reset", 32'(ack_cnt - a0), 32'd0);
    // Pointer back at 0: requester 0 beats 3 even though 3 was next before reset.
    req_data = 32'hC300_000F;
    push_exp(3'd0, 8'h0F, 1'b1);
    push_exp(3'd3, 8'hC3, 1'b1);
    req = 4'b1001;
    check_ack(cyc);
    req = 4'b1000;
    check_ack(cyc);
    req = '0;
    wait_idle();
    check_lines();

    // One-clock request while idle: reaches GRANT with nothing pending.
    a0  = ack_cnt;
    e0  = en_rise;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (10) @(negedge clk);
    chk("blip_idle_acks", 32'(ack_cnt - a0), 32'd0);
    chk("blip_idle_en", 32'(en_rise - e0), 32'd0);

    // One-clock request from 0 during another requester's frame.
    req_data = 32'h0000_9900;
    push_exp(3'd1, 8'h99, 1'b1);
    a0  = ack_cnt;
    e0  = en_rise;
    z0  = ack0_cnt;
    req = 4'b0010;
    check_ack(cyc);
    req = '0;
    wait_busy(1'b1);
    repeat (5) @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_idle();
    repeat (20) @(negedge clk);
    wait_idle();
    check_lines();
    chk("wd_ack0", 32'(ack0_cnt - z0), 32'd0);
    chk("wd_ack_count", 32'(ack_cnt - a0), 32'd1);
    chk("wd_en_rises", 32'(en_rise - e0), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
